// File: rtl/receiver_interface_pkg.sv
// Shared types and constants for the receive-path packet slot buffer.
//   rx_state_t : write-side FSM states
//   pkt_desc_t : committed packet descriptor (slot index, byte length)
//   RX_CNT_W   : width of the saturating drop/error event counters
//   sat_inc    : saturating increment helper for those counters
package receiver_interface_pkg;

    localparam int RX_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    // Fields are sized for the largest supported configuration; the top
    // narrows them to its own parameterised widths.
    typedef struct packed {
        logic [7:0]  slot;
        logic [15:0] len;
    } pkt_desc_t;

    function automatic logic [RX_CNT_W-1:0] sat_inc(input logic [RX_CNT_W-1:0] cnt,
                                                     input logic              en);
        return (en && (cnt != '1)) ? cnt + RX_CNT_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/receiver_interface_slot_ram.sv
// Simple dual-port packet RAM: one write port, one read port with a
// registered output. The read register holds when re is low and clears on
// reset so the read data output starts at zero.
//   clk_net, rst      : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata  : write port
//   re, raddr, rdata  : read port, rdata valid one cycle after re
module receiver_interface_slot_ram #(
    parameter int AW = 5,
    parameter int DW = 64
) (
    input  logic          clk_net,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Address is {slot, beat}, so the array spans the full concatenated range.
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_net) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_net) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/receiver_interface_packet_slot_buffer.sv
// Multi-slot receive packet buffer. Beats from the MAC stream are written
// into NUM_SLOTS fixed-size slots; on EOP a descriptor is committed one
// cycle later and packets are handed out in arrival order via a
// valid/ready release handshake.
//   clk_net, rst                 : clock, synchronous active-high reset
//   valid, sop, eop, length, data: MAC-side beat stream (no backpressure)
//   pkt_valid/ready/slot/len     : head descriptor and release handshake
//   rd_en, rd_beat, rd_data      : beat read from head slot, 1-cycle latency
//   occupancy                    : committed, unreleased slots
//   drop_cnt, err_cnt            : saturating drop / protocol-error counters
module receiver_interface_packet_slot_buffer
    import receiver_interface_pkg::*;
#(
    parameter int BEAT_BYTES    = 8,
    parameter int MAX_PKT_BYTES = 1536,
    parameter int NUM_SLOTS     = 4,
    localparam int LEN_W  = $clog2(BEAT_BYTES),
    localparam int SLOT_W = $clog2(NUM_SLOTS),
    localparam int PLEN_W = $clog2(MAX_PKT_BYTES + 1),
    localparam int BEAT_W = $clog2(MAX_PKT_BYTES / BEAT_BYTES),
    localparam int OCC_W  = SLOT_W + 1,
    localparam int DATA_W = 8 * BEAT_BYTES
) (
    input  logic                clk_net,
    input  logic                rst,
    input  logic                valid,
    input  logic                sop,
    input  logic                eop,
    input  logic [LEN_W-1:0]    length,
    input  logic [DATA_W-1:0]   data,
    output logic                pkt_valid,
    input  logic                pkt_ready,
    output logic [SLOT_W-1:0]   pkt_slot,
    output logic [PLEN_W-1:0]   pkt_len,
    input  logic                rd_en,
    input  logic [BEAT_W-1:0]   rd_beat,
    output logic [DATA_W-1:0]   rd_data,
    output logic [OCC_W-1:0]    occupancy,
    output logic [RX_CNT_W-1:0] drop_cnt,
    output logic [RX_CNT_W-1:0] err_cnt
);

    // One spare bit so a running count can be compared past the slot size.
    localparam int CNT_W = PLEN_W + 1;

    rx_state_t             state_q, state_d;
    logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]     rd_slot_q;
    logic [PLEN_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                  pend_q, pend_d;
    pkt_desc_t             pend_desc_q, pend_desc_d;
    logic [OCC_W-1:0]      occ_q;
    logic [RX_CNT_W-1:0]   drop_cnt_q, err_cnt_q;

    logic                  wr_en;
    logic [BEAT_W-1:0]     wr_beat;
    logic                  drop_inc, err_inc;
    logic                  full, release_w;
    logic [CNT_W-1:0]      beat_add, acc_cnt;
    logic [PLEN_W-1:0]     len_arr [NUM_SLOTS];

    assign beat_add  = eop ? (CNT_W'(length) + CNT_W'(1)) : CNT_W'(BEAT_BYTES);
    assign acc_cnt   = CNT_W'(byte_cnt_q) + beat_add;
    assign release_w = pkt_valid && pkt_ready;

    // A descriptor accepted last cycle is not yet in occ_q but already owns
    // its slot, so it counts toward full.
    assign full = ((OCC_W+1)'(occ_q) + (OCC_W+1)'(pend_q)) >= (OCC_W+1)'(NUM_SLOTS);

    always_comb begin
        state_d     = state_q;
        wr_slot_d   = wr_slot_q;
        byte_cnt_d  = byte_cnt_q;
        pend_d      = 1'b0;
        pend_desc_d = pend_desc_q;
        wr_en       = 1'b0;
        wr_beat     = '0;
        drop_inc    = 1'b0;
        err_inc     = 1'b0;

        if (valid && sop) begin
            // SOP is handled identically in every state; inside RECV it
            // additionally abandons the partial packet and restarts the slot.
            if (state_q == RECV) begin
                err_inc = 1'b1;
            end
            if (!full) begin
                wr_en = 1'b1;
                if (eop) begin
                    pend_d      = 1'b1;
                    pend_desc_d = '{slot: 8'(wr_slot_q), len: 16'(beat_add)};
                    wr_slot_d   = wr_slot_q + SLOT_W'(1);
                    state_d     = IDLE;
                end else begin
                    byte_cnt_d = PLEN_W'(beat_add);
                    state_d    = RECV;
                end
            end else begin
                drop_inc = 1'b1;
                state_d  = eop ? IDLE : DROP;
            end
        end else if (valid) begin
            case (state_q)
                IDLE: err_inc = eop;
                RECV: begin
                    if (acc_cnt > CNT_W'(MAX_PKT_BYTES)) begin
                        err_inc = 1'b1;
                        state_d = eop ? IDLE : DROP;
                    end else begin
                        wr_en      = 1'b1;
                        // Every non-final beat is full, so the beat index is
                        // the byte count divided by the beat size.
                        wr_beat    = byte_cnt_q[LEN_W +: BEAT_W];
                        byte_cnt_d = PLEN_W'(acc_cnt);
                        if (eop) begin
                            pend_d      = 1'b1;
                            pend_desc_d = '{slot: 8'(wr_slot_q), len: 16'(acc_cnt)};
                            wr_slot_d   = wr_slot_q + SLOT_W'(1);
                            state_d     = IDLE;
                        end
                    end
                end
                DROP: if (eop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_net) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_slot_q   <= '0;
            rd_slot_q   <= '0;
            byte_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_desc_q <= '0;
            occ_q       <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_q + SLOT_W'(release_w);
            byte_cnt_q  <= byte_cnt_d;
            pend_q      <= pend_d;
            pend_desc_q <= pend_desc_d;
            occ_q       <= occ_q + OCC_W'(pend_q) - OCC_W'(release_w);
            drop_cnt_q  <= sat_inc(drop_cnt_q, drop_inc);
            err_cnt_q   <= sat_inc(err_cnt_q, err_inc);
        end
    end

    // Per-slot length registers, loaded in the same cycle the descriptor
    // becomes visible through occupancy.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_len
        logic [PLEN_W-1:0] len_q;
        always_ff @(posedge clk_net) begin
            if (rst) begin
                len_q <= '0;
            end else if (pend_q && (SLOT_W'(pend_desc_q.slot) == SLOT_W'(gi))) begin
                len_q <= PLEN_W'(pend_desc_q.len);
            end
        end
        assign len_arr[gi] = len_q;
    end

    receiver_interface_slot_ram #(
        .AW (SLOT_W + BEAT_W),
        .DW (DATA_W)
    ) u_ram (
        .clk_net (clk_net),
        .rst     (rst),
        .we      (wr_en),
        .waddr   ({wr_slot_q, wr_beat}),
        .wdata   (data),
        .re      (rd_en),
        .raddr   ({rd_slot_q, rd_beat}),
        .rdata   (rd_data)
    );

    assign pkt_valid = (occ_q != '0);
    assign pkt_slot  = rd_slot_q;
    assign pkt_len   = len_arr[rd_slot_q];
    assign occupancy = occ_q;
    assign drop_cnt  = drop_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_receiver_interface_packet_slot_buffer.sv
module tb_receiver_interface_packet_slot_buffer;

    logic        clk_net = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, sop = 1'b0, eop = 1'b0;
    logic [2:0]  length = '0;
    logic [63:0] data = '0;
    logic        pkt_ready = 1'b0, rd_en = 1'b0;
    logic [2:0]  rd_beat = '0;
    logic        pkt_valid;
    logic [1:0]  pkt_slot;
    logic [6:0]  pkt_len;
    logic [63:0] rd_data;
    logic [2:0]  occupancy;
    logic [15:0] drop_cnt, err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    receiver_interface_packet_slot_buffer #(
        .BEAT_BYTES    (8),
        .MAX_PKT_BYTES (64),
        .NUM_SLOTS     (4)
    ) dut (
        .clk_net   (clk_net),
        .rst       (rst),
        .valid     (valid),
        .sop       (sop),
        .eop       (eop),
        .length    (length),
        .data      (data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_slot  (pkt_slot),
        .pkt_len   (pkt_len),
        .rd_en     (rd_en),
        .rd_beat   (rd_beat),
        .rd_data   (rd_data),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk_net = ~clk_net;

    typedef struct {
        logic        v, s, e;
        logic [2:0]  len;
        logic [63:0] d;
        logic        rdy, rden;
        logic [2:0]  rb;
        logic        pv;
        logic [1:0]  slot;
        logic [6:0]  plen;
        logic [2:0]  occ;
        logic [15:0] err;
        logic        chk_rd;
        logic [63:0] rdd;
    } vec_t;

    localparam int NV = 28;
    vec_t tv [NV];

    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8{b}} ^ 64'h0706050403020100;
    endfunction

    function automatic vec_t mk(input int v, s, e, len, input logic [63:0] d,
                                input int rdy, rden, rb, pv, slot, plen, occ, err, chk,
                                input logic [63:0] rdd);
        vec_t m;
        m.v = 1'(v);  m.s = 1'(s);  m.e = 1'(e);  m.len = 3'(len);  m.d = d;
        m.rdy = 1'(rdy);  m.rden = 1'(rden);  m.rb = 3'(rb);
        m.pv = 1'(pv);  m.slot = 2'(slot);  m.plen = 7'(plen);  m.occ = 3'(occ);
        m.err = 16'(err);  m.chk_rd = 1'(chk);  m.rdd = rdd;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_net);
        #1;
    endtask

    task automatic idle_in();
        valid = 1'b0; sop = 1'b0; eop = 1'b0; length = '0; data = '0;
        pkt_ready = 1'b0; rd_en = 1'b0; rd_beat = '0;
    endtask

    task automatic drive(input logic s, input logic e, input logic [2:0] l, input logic [63:0] d);
        valid = 1'b1; sop = s; eop = e; length = l; data = d;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic send_pkt2(input int k, input logic [2:0] l);
        drive(1'b1, 1'b0, 3'd0, pat(k));
        cyc();
        drive(1'b0, 1'b1, l, pat(k + 1));
        cyc();
        idle_in();
    endtask

    task automatic read_beat(input string name, input logic [2:0] b, input logic [63:0] exp);
        rd_en = 1'b1; rd_beat = b;
        cyc();
        rd_en = 1'b0;
        chk(name, rd_data, exp);
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_pv"},   64'(pkt_valid), 64'd0);
        chk({tag, "_slot"}, 64'(pkt_slot),  64'd0);
        chk({tag, "_len"},  64'(pkt_len),   64'd0);
        chk({tag, "_occ"},  64'(occupancy), 64'd0);
        chk({tag, "_drop"}, 64'(drop_cnt),  64'd0);
        chk({tag, "_err"},  64'(err_cnt),   64'd0);
        chk({tag, "_rdd"},  rd_data,        64'd0);
    endtask

    initial begin
        //         v s e l data     rdy re rb | pv sl len occ err chk rdd
        tv[0]  = mk(1,1,0,0,pat(1),  0,0,0,  0,0,0, 0,0, 0,64'd0);
        tv[1]  = mk(1,0,0,0,pat(2),  0,0,0,  0,0,0, 0,0, 0,64'd0);
        tv[2]  = mk(1,0,1,4,pat(3),  0,0,0,  0,0,0, 0,0, 0,64'd0);   // commit not yet visible
        tv[3]  = mk(0,0,0,0,64'd0,   0,0,0,  1,0,21,1,0, 0,64'd0);
        tv[4]  = mk(0,0,0,0,64'd0,   0,1,0,  1,0,21,1,0, 1,pat(1));
        tv[5]  = mk(0,0,0,0,64'd0,   0,1,1,  1,0,21,1,0, 1,pat(2));
        tv[6]  = mk(0,0,0,0,64'd0,   0,1,2,  1,0,21,1,0, 1,pat(3));
        tv[7]  = mk(0,0,0,0,64'd0,   0,0,0,  1,0,21,1,0, 1,pat(3));  // rd_data holds
        tv[8]  = mk(0,0,0,0,64'd0,   1,0,0,  0,1,0, 0,0, 1,pat(3));
        tv[9]  = mk(1,1,1,0,pat(4),  0,0,0,  0,1,0, 0,0, 0,64'd0);   // single-beat packet
        tv[10] = mk(0,0,0,0,64'd0,   0,0,0,  1,1,1, 1,0, 0,64'd0);
        tv[11] = mk(0,0,0,0,64'd0,   0,1,0,  1,1,1, 1,0, 1,pat(4));
        tv[12] = mk(0,0,0,0,64'd0,   1,0,0,  0,2,0, 0,0, 0,64'd0);
        tv[13] = mk(1,1,0,0,pat(5),  0,0,0,  0,2,0, 0,0, 0,64'd0);   // 9-beat oversize packet
        for (int i = 14; i <= 20; i++) tv[i] = mk(1,0,0,0,pat(i-8), 0,0,0, 0,2,0,0,0, 0,64'd0);
        tv[21] = mk(1,0,1,7,pat(13), 0,0,0,  0,2,0, 0,1, 0,64'd0);
        tv[22] = mk(0,0,0,0,64'd0,   0,0,0,  0,2,0, 0,1, 0,64'd0);
        tv[23] = mk(1,1,0,0,pat(14), 0,0,0,  0,2,0, 0,1, 0,64'd0);
        tv[24] = mk(1,0,1,7,pat(15), 0,0,0,  0,2,0, 0,1, 0,64'd0);
        tv[25] = mk(0,0,0,0,64'd0,   0,0,0,  1,2,16,1,1, 0,64'd0);
        tv[26] = mk(0,0,0,0,64'd0,   0,1,1,  1,2,16,1,1, 1,pat(15));
        tv[27] = mk(0,0,0,0,64'd0,   1,0,0,  0,3,0, 0,1, 0,64'd0);

        do_reset();
        chk_zero_state("reset0");

        for (int i = 0; i < NV; i++) begin
            valid = tv[i].v; sop = tv[i].s; eop = tv[i].e; length = tv[i].len; data = tv[i].d;
            pkt_ready = tv[i].rdy; rd_en = tv[i].rden; rd_beat = tv[i].rb;
            cyc();
            $display("vec %0d: v=%0b sop=%0b eop=%0b -> pv=%0b slot=%0d len=%0d occ=%0d err=%0d",
                     i, tv[i].v, tv[i].s, tv[i].e, pkt_valid, pkt_slot, pkt_len, occupancy, err_cnt);
            chk($sformatf("v%0d_pv", i),   64'(pkt_valid), 64'(tv[i].pv));
            chk($sformatf("v%0d_slot", i), 64'(pkt_slot),  64'(tv[i].slot));
            chk($sformatf("v%0d_len", i),  64'(pkt_len),   64'(tv[i].plen));
            chk($sformatf("v%0d_occ", i),  64'(occupancy), 64'(tv[i].occ));
            chk($sformatf("v%0d_err", i),  64'(err_cnt),   64'(tv[i].err));
            if (tv[i].chk_rd) chk($sformatf("v%0d_rdd", i), rd_data, tv[i].rdd);
        end
        idle_in();
        chk("table_drop", 64'(drop_cnt), 64'd0);

        // Five back-to-back packets into four slots; the fifth is dropped.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            send_pkt2(40 + 2 * p, 3'(p));
            $display("full-test packet %0d sent: occ=%0d drop=%0d", p, occupancy, drop_cnt);
        end
        cyc();
        chk("full_occ",  64'(occupancy), 64'd4);
        chk("full_drop", 64'(drop_cnt),  64'd1);
        chk("full_slot", 64'(pkt_slot),  64'd0);
        chk("full_len",  64'(pkt_len),   64'd9);
        pkt_ready = 1'b1;
        cyc();
        pkt_ready = 1'b0;
        chk("pop1_occ",  64'(occupancy), 64'd3);
        chk("pop1_slot", 64'(pkt_slot),  64'd1);
        send_pkt2(60, 3'd6);
        cyc();
        $display("wrap packet sent: occ=%0d drop=%0d", occupancy, drop_cnt);
        chk("wrap_occ",  64'(occupancy), 64'd4);
        chk("wrap_drop", 64'(drop_cnt),  64'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain%0d_slot", i), 64'(pkt_slot), 64'(i + 1));
            chk($sformatf("drain%0d_len", i),  64'(pkt_len),  64'(10 + i));
            pkt_ready = 1'b1;
            cyc();
            pkt_ready = 1'b0;
        end
        chk("wrap_head_slot", 64'(pkt_slot),  64'd0);
        chk("wrap_head_len",  64'(pkt_len),   64'd15);
        chk("wrap_head_occ",  64'(occupancy), 64'd1);
        read_beat("wrap_rd0", 3'd0, pat(60));
        read_beat("wrap_rd1", 3'd1, pat(61));

        // SOP arriving as beat 3 of a packet restarts it in the same slot.
        do_reset();
        drive(1'b1, 1'b0, 3'd0, pat(70)); cyc();
        drive(1'b0, 1'b0, 3'd0, pat(71)); cyc();
        drive(1'b0, 1'b0, 3'd0, pat(72)); cyc();
        drive(1'b1, 1'b0, 3'd0, pat(73)); cyc();
        chk("restart_err_now", 64'(err_cnt), 64'd1);
        drive(1'b0, 1'b1, 3'd7, pat(74)); cyc();
        idle_in(); cyc();
        $display("restart packet: slot=%0d len=%0d err=%0d", pkt_slot, pkt_len, err_cnt);
        chk("restart_err",  64'(err_cnt),   64'd1);
        chk("restart_occ",  64'(occupancy), 64'd1);
        chk("restart_len",  64'(pkt_len),   64'd16);
        chk("restart_slot", 64'(pkt_slot),  64'd0);
        read_beat("restart_rd0", 3'd0, pat(73));
        read_beat("restart_rd1", 3'd1, pat(74));
        pkt_ready = 1'b1; cyc(); pkt_ready = 1'b0;
        chk("restart_single_occ", 64'(occupancy), 64'd0);
        chk("restart_single_pv",  64'(pkt_valid), 64'd0);

        // Reset mid-packet with two committed packets.
        do_reset();
        drive(1'b1, 1'b1, 3'd2, pat(80)); cyc();
        drive(1'b1, 1'b1, 3'd3, pat(81)); cyc();
        drive(1'b1, 1'b0, 3'd0, pat(82)); cyc();
        idle_in(); cyc();
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        read_beat("pre_rst_rd", 3'd0, pat(80));
        rst = 1'b1; cyc(); rst = 1'b0;
        $display("mid-packet reset: pv=%0b occ=%0d rd_data=%0h", pkt_valid, occupancy, rd_data);
        chk_zero_state("midrst");
        drive(1'b0, 1'b0, 3'd0, pat(83)); cyc();
        chk("post_rst_beat_err", 64'(err_cnt), 64'd0);
        drive(1'b0, 1'b1, 3'd5, pat(84)); cyc();
        idle_in();
        chk("orphan_eop_err", 64'(err_cnt),   64'd1);
        cyc();
        chk("orphan_occ",     64'(occupancy), 64'd0);
        chk("orphan_pv",      64'(pkt_valid), 64'd0);

        // Commit and release landing in the same cycle.
        drive(1'b1, 1'b1, 3'd0, pat(85)); cyc();
        idle_in(); cyc();
        chk("cr_occ_a",  64'(occupancy), 64'd1);
        chk("cr_len_a",  64'(pkt_len),   64'd1);
        drive(1'b1, 1'b1, 3'd1, pat(86)); cyc();
        idle_in();
        pkt_ready = 1'b1; cyc(); pkt_ready = 1'b0;
        $display("commit+pop: occ=%0d slot=%0d len=%0d", occupancy, pkt_slot, pkt_len);
        chk("cr_occ_b",  64'(occupancy), 64'd1);
        chk("cr_slot_b", 64'(pkt_slot),  64'd1);
        chk("cr_len_b",  64'(pkt_len),   64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/receiver_interface_packet_slot_buffer.md
# receiver_interface_packet_slot_buffer

Multi-slot packet buffer for the receive path: captures beats from the MAC-side streaming interface into `NUM_SLOTS` fixed-size packet slots, commits a descriptor (slot, byte length) on EOP, and hands completed packets to the parser in arrival order. It replaces the single-packet buffer wherever back-to-back packets must be absorbed while the parser is still reading the previous one. It adds bus-width parametrisation, oversize/overflow drop handling, protocol-error counting and a ready/valid release handshake.

## Interface
- `BEAT_BYTES`, 8: bytes per beat; power of two ≥ 2.
- `MAX_PKT_BYTES`, 1536: slot capacity in bytes; must be a multiple of `BEAT_BYTES`.
- `NUM_SLOTS`, 4: packet slots; power of two ≥ 2.
- `clk_net  in  1`: receive clock.
- `rst  in  1`: synchronous, active-high reset.
- `valid  in  1`: beat qualifier.
- `sop  in  1`: first beat of packet (qualified by `valid`).
- `eop  in  1`: last beat of packet (qualified by `valid`).
- `length  in  $clog2(BEAT_BYTES)`: on EOP beat, valid bytes minus 1; ignored otherwise.
- `data  in  8*BEAT_BYTES`: beat data, byte 0 in bits [7:0].
- `pkt_valid  out  1`: head descriptor available.
- `pkt_ready  in  1`: consumer releases head slot.
- `pkt_slot  out  $clog2(NUM_SLOTS)`: head slot index.
- `pkt_len  out  $clog2(MAX_PKT_BYTES+1)`: head packet length in bytes.
- `rd_en  in  1`, `rd_beat  in  $clog2(MAX_PKT_BYTES/BEAT_BYTES)`: beat read from head slot.
- `rd_data  out  8*BEAT_BYTES`: read data.
- `occupancy  out  $clog2(NUM_SLOTS)+1`: committed, unreleased slots.
- `drop_cnt  out  16`, `err_cnt  out  16`: saturating event counters.

## Operation
- Write FSM states: IDLE, RECV, DROP.
- IDLE, `valid&&sop`:
  - If `occupancy < NUM_SLOTS`, write beat 0 to slot `wr_slot`; go to RECV, or commit immediately if `eop` is also set.
  - If full, `drop_cnt++`; go to DROP, or stay in IDLE if `eop`.
- IDLE, `valid&&!sop`: beat ignored. `err_cnt++` only if `eop` (orphan EOP).
- RECV, `valid&&!sop`: write beat at `beat_idx`, `byte_cnt += eop ? length+1 : BEAT_BYTES`.
  - If the beat would take `byte_cnt` past `MAX_PKT_BYTES`: no write, `err_cnt++`, go to DROP, or to IDLE if `eop`.
  - Otherwise, `eop` commits and the FSM returns to IDLE.
- RECV, `valid&&sop`: `err_cnt++`; the partial packet is abandoned. The new packet restarts at beat 0 of the same slot and is handled as a fresh SOP.
- DROP: beats discarded. `valid&&eop&&!sop` → IDLE. `valid&&sop` is evaluated exactly as in IDLE.
- Commit:
  - Store `byte_cnt` (including the EOP beat) in the slot's length register.
  - `wr_slot++` (wraps modulo `NUM_SLOTS`), `occupancy++`.
- Release: `pkt_valid&&pkt_ready` → `rd_slot++` (wraps), `occupancy--`.
  - Commit and release in the same cycle leave `occupancy` unchanged.
- `pkt_valid = (occupancy != 0)`. `pkt_slot = rd_slot`. `pkt_len` = length register of `rd_slot`.
- Reads:
  - `rd_en` reads beat `rd_beat` of slot `rd_slot`. Reads have no side effects.
  - Data beyond `pkt_len`, or read while `!pkt_valid`, is stale but defined (last written RAM content).
  - Bytes above `length` in the EOP beat are stored as received.
- Counters saturate at 0xFFFF.

## Timing
- Reset values:
  - `pkt_valid`, `pkt_slot`, `pkt_len`, `rd_data`, `occupancy`, `drop_cnt`, `err_cnt` all 0.
  - FSM in IDLE, `wr_slot`/`rd_slot` = 0.
  - Packets in flight or committed are discarded.
- Reset mid-packet: post-reset beats without SOP are ignored. An orphan EOP counts in `err_cnt`.
- Commit latency: EOP beat accepted at edge N → `pkt_valid`/`pkt_len` updated after edge N+1 (registered). Same-cycle flow-through is not allowed.
- Full is evaluated on registered `occupancy`. A slot released at edge N is usable by an SOP sampled at edge N+1 or later, not at edge N.
- `rd_data` latency: 1 cycle after `rd_en`. It holds its value when `rd_en` = 0.
- No backpressure toward the MAC: every beat is accepted or dropped in the cycle it is presented.

## Structure
- Package `receiver_interface_pkg`:
  - `rx_state_t` enum (IDLE/RECV/DROP).
  - `pkt_desc_t` struct {slot, len}.
  - Counter width constant `RX_CNT_W = 16`.
- Sub-module `receiver_interface_slot_ram`: simple dual-port RAM, one write and one registered read port.
  - `NUM_SLOTS*MAX_PKT_BYTES/BEAT_BYTES` words × `8*BEAT_BYTES` bits.
  - Address `{slot, beat}`.
- FSM, pointers, length registers and counters live in the top level.

## Test plan
All scenarios use `BEAT_BYTES=8, MAX_PKT_BYTES=64, NUM_SLOTS=4`.
- 3-beat packet, EOP `length=4`:
  - `pkt_valid` rises after the edge following EOP, with `pkt_slot=0`, `pkt_len=21`.
  - `rd_beat=0..2` returns the sent beats 1 cycle after `rd_en`.
- Single beat `sop&&eop`, `length=0` → `pkt_len=1`, `occupancy=1`.
- Five packets with `pkt_ready=0`:
  - Result: `occupancy=4`, `drop_cnt=1`, and the 5th packet is never visible.
  - Pop one, then send another → it lands in slot 0 after wrap, `occupancy=4`.
- 9-beat packet (72 bytes) → `err_cnt=1`, no descriptor, `occupancy=0`. The following 2-beat packet commits with `pkt_len=16`.
- SOP at beat 3 of a packet, then 2 beats with EOP `length=7` → `err_cnt=1`, a single descriptor with `pkt_len=16`.
- `rst` asserted mid-packet with 2 packets committed:
  - All outputs return to 0.
  - A subsequent non-SOP EOP beat → `err_cnt=1`.
  - A simultaneous commit and pop keeps `occupancy` constant.
